// File: rtl/pcf8591_sched_if.sv
// Byte-level command channel between the PCF8591 scheduler and the shared I2C byte master.
// master: scheduler side (drives commands); slave: byte-master side (accepts, completes).
interface pcf8591_sched_if;
    logic       m_valid;
    logic       m_ready;
    logic [1:0] m_cmd;
    logic [7:0] m_wdata;
    logic       m_last;
    logic       m_done;
    logic [7:0] m_rdata;
    logic       m_nack;

    modport master (
        output m_valid, m_cmd, m_wdata, m_last,
        input  m_ready, m_done, m_rdata, m_nack
    );

    modport slave (
        input  m_valid, m_cmd, m_wdata, m_last,
        output m_ready, m_done, m_rdata, m_nack
    );
endinterface

// File: rtl/pcf8591_sched.sv
// PCF8591 scheduler: round-robin DAC-write / ADC-read arbitration, expanded into I2C byte commands.
// Latency: first command 1 cycle after grant; each step >= 2 cycles + master latency; result 1 cycle after last m_done.
// Backpressure: command held stable while m_valid && !m_ready. Optional PCF_AUTOSCAN_EN adds a periodic ADC scan.
module pcf8591_sched #(
    parameter logic [6:0]  DEV_ADDR    = 7'b1001000,
    parameter logic [23:0] SCAN_PERIOD = 24'd100000
) (
    input  logic                   sysclk,
    input  logic                   reset,
    input  logic                   dac_req,
    input  logic [7:0]             dac_data,
    output logic                   dac_ack,
    input  logic                   adc_req,
    input  logic [1:0]             adc_chan,
    output logic                   adc_valid,
    output logic [7:0]             adc_data,
    output logic [1:0]             adc_tag,
    output logic                   err,
    pcf8591_sched_if.master        m_if
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ABORT, FINISH} state_t;

    localparam logic [1:0] CMD_START = 2'd0;
    localparam logic [1:0] CMD_WRITE = 2'd1;
    localparam logic [1:0] CMD_READ  = 2'd2;
    localparam logic [1:0] CMD_STOP  = 2'd3;

    typedef struct packed {
        logic [1:0] cmd;
        logic [7:0] wdata;
        logic       last;
    } cmd_t;

    // Command for a given step of the DAC or ADC sequence; control byte keeps bit6 (DAC enable) set.
    function automatic cmd_t step_cmd(input logic is_adc, input logic [3:0] step,
                                      input logic [7:0] dval, input logic [1:0] chan);
        cmd_t c;
        c = '0;
        if (!is_adc) begin
            case (step)
                4'd0:    c.cmd = CMD_START;
                4'd1:    begin c.cmd = CMD_WRITE; c.wdata = {DEV_ADDR, 1'b0}; end
                4'd2:    begin c.cmd = CMD_WRITE; c.wdata = 8'h40; end
                4'd3:    begin c.cmd = CMD_WRITE; c.wdata = dval; end
                default: c.cmd = CMD_STOP;
            endcase
        end else begin
            case (step)
                4'd0:    c.cmd = CMD_START;
                4'd1:    begin c.cmd = CMD_WRITE; c.wdata = {DEV_ADDR, 1'b0}; end
                4'd2:    begin c.cmd = CMD_WRITE; c.wdata = {6'b010000, chan}; end
                4'd3:    c.cmd = CMD_STOP;
                4'd4:    c.cmd = CMD_START;
                4'd5:    begin c.cmd = CMD_WRITE; c.wdata = {DEV_ADDR, 1'b1}; end
                4'd6:    begin c.cmd = CMD_READ; c.last = 1'b0; end
                4'd7:    begin c.cmd = CMD_READ; c.last = 1'b1; end
                default: c.cmd = CMD_STOP;
            endcase
        end
        return c;
    endfunction

    state_t     state_q,     state_d;
    logic [3:0] step_q,      step_d;
    logic       is_adc_q,    is_adc_d;
    logic [7:0] dval_q,      dval_d;
    logic [1:0] chan_q,      chan_d;
    logic       last_adc_q,  last_adc_d;
    logic       err_flag_q,  err_flag_d;
    logic [7:0] result_q,    result_d;
    logic       m_valid_q,   m_valid_d;
    cmd_t       cmd_q,       cmd_d;
    logic       dac_ack_q,   dac_ack_d;
    logic       adc_valid_q, adc_valid_d;
    logic [7:0] adc_data_q,  adc_data_d;
    logic [1:0] adc_tag_q,   adc_tag_d;
    logic       err_q,       err_d;

`ifdef PCF_AUTOSCAN_EN
    logic [23:0] scan_cnt_q,  scan_cnt_d;
    logic        scan_pend_q, scan_pend_d;
    logic [1:0]  scan_chan_q, scan_chan_d;
    logic        is_scan_q,   is_scan_d;
`else
    logic unused_scan_period;
    assign unused_scan_period = ^SCAN_PERIOD;
`endif

    logic       granted;
    logic       finish_now;
    logic [3:0] last_step;
    logic [3:0] step_inc;
    cmd_t       next_cmd;

    assign last_step = is_adc_q ? 4'd8 : 4'd4;
    assign step_inc  = step_q + 4'd1;
    assign next_cmd  = step_cmd(is_adc_q, step_inc, dval_q, chan_q);

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        is_adc_d    = is_adc_q;
        dval_d      = dval_q;
        chan_d      = chan_q;
        last_adc_d  = last_adc_q;
        err_flag_d  = err_flag_q;
        result_d    = result_q;
        m_valid_d   = m_valid_q;
        cmd_d       = cmd_q;
        dac_ack_d   = 1'b0;
        adc_valid_d = 1'b0;
        adc_data_d  = adc_data_q;
        adc_tag_d   = adc_tag_q;
        err_d       = 1'b0;
        granted     = 1'b0;
        finish_now  = 1'b0;
`ifdef PCF_AUTOSCAN_EN
        scan_chan_d = scan_chan_q;
        is_scan_d   = is_scan_q;
        scan_cnt_d  = (scan_cnt_q == SCAN_PERIOD - 24'd1) ? 24'd0 : scan_cnt_q + 24'd1;
        // A wrap while the flag is already pending simply merges into it.
        scan_pend_d = scan_pend_q | (scan_cnt_q == SCAN_PERIOD - 24'd1);
`endif

        case (state_q)
            IDLE: begin
                // Tie goes to whichever side was not granted last.
                if (dac_req && (!adc_req || last_adc_q)) begin
                    granted    = 1'b1;
                    is_adc_d   = 1'b0;
                    dval_d     = dac_data;
                    last_adc_d = 1'b0;
`ifdef PCF_AUTOSCAN_EN
                    is_scan_d  = 1'b0;
`endif
                end else if (adc_req) begin
                    granted    = 1'b1;
                    is_adc_d   = 1'b1;
                    chan_d     = adc_chan;
                    last_adc_d = 1'b1;
`ifdef PCF_AUTOSCAN_EN
                    is_scan_d  = 1'b0;
                end else if (scan_pend_q) begin
                    granted     = 1'b1;
                    is_adc_d    = 1'b1;
                    chan_d      = scan_chan_q;
                    is_scan_d   = 1'b1;
                    scan_pend_d = 1'b0;
`endif
                end
                if (granted) begin
                    state_d   = ISSUE;
                    step_d    = 4'd0;
                    m_valid_d = 1'b1;
                    cmd_d     = '0;
                    cmd_d.cmd = CMD_START;
                end
            end
            ISSUE: begin
                if (m_if.m_ready) begin
                    m_valid_d = 1'b0;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (m_if.m_done) begin
                    if (cmd_q.cmd == CMD_READ && cmd_q.last) begin
                        result_d = m_if.m_rdata;
                    end
                    if (cmd_q.cmd == CMD_WRITE && m_if.m_nack) begin
                        err_flag_d = 1'b1;
                        state_d    = ABORT;
                        m_valid_d  = 1'b1;
                        cmd_d      = '0;
                        cmd_d.cmd  = CMD_STOP;
                    end else if (step_q == last_step) begin
                        finish_now = 1'b1;
                    end else begin
                        step_d    = step_inc;
                        state_d   = ISSUE;
                        m_valid_d = 1'b1;
                        cmd_d     = next_cmd;
                    end
                end
            end
            ABORT: begin
                // m_valid low here means the STOP is in flight and m_done is meaningful.
                if (m_valid_q) begin
                    if (m_if.m_ready) begin
                        m_valid_d = 1'b0;
                    end
                end else if (m_if.m_done) begin
                    finish_now = 1'b1;
                end
            end
            FINISH: begin
                err_flag_d = 1'b0;
                state_d    = IDLE;
`ifdef PCF_AUTOSCAN_EN
                if (is_scan_q) begin
                    scan_chan_d = scan_chan_q + 2'd1;
                    is_scan_d   = 1'b0;
                end
`endif
            end
            default: state_d = IDLE;
        endcase

        if (finish_now) begin
            state_d = FINISH;
            err_d   = err_flag_q;
            if (is_adc_q) begin
                adc_valid_d = 1'b1;
                adc_tag_d   = chan_q;
                adc_data_d  = err_flag_q ? 8'h00 : result_q;
            end else begin
                dac_ack_d = 1'b1;
            end
        end
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            step_q      <= 4'd0;
            is_adc_q    <= 1'b0;
            dval_q      <= 8'h00;
            chan_q      <= 2'd0;
            last_adc_q  <= 1'b1;
            err_flag_q  <= 1'b0;
            result_q    <= 8'h00;
            m_valid_q   <= 1'b0;
            cmd_q       <= '0;
            dac_ack_q   <= 1'b0;
            adc_valid_q <= 1'b0;
            adc_data_q  <= 8'h00;
            adc_tag_q   <= 2'd0;
            err_q       <= 1'b0;
`ifdef PCF_AUTOSCAN_EN
            scan_cnt_q  <= 24'd0;
            scan_pend_q <= 1'b0;
            scan_chan_q <= 2'd0;
            is_scan_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            is_adc_q    <= is_adc_d;
            dval_q      <= dval_d;
            chan_q      <= chan_d;
            last_adc_q  <= last_adc_d;
            err_flag_q  <= err_flag_d;
            result_q    <= result_d;
            m_valid_q   <= m_valid_d;
            cmd_q       <= cmd_d;
            dac_ack_q   <= dac_ack_d;
            adc_valid_q <= adc_valid_d;
            adc_data_q  <= adc_data_d;
            adc_tag_q   <= adc_tag_d;
            err_q       <= err_d;
`ifdef PCF_AUTOSCAN_EN
            scan_cnt_q  <= scan_cnt_d;
            scan_pend_q <= scan_pend_d;
            scan_chan_q <= scan_chan_d;
            is_scan_q   <= is_scan_d;
`endif
        end
    end

    assign dac_ack        = dac_ack_q;
    assign adc_valid      = adc_valid_q;
    assign adc_data       = adc_data_q;
    assign adc_tag        = adc_tag_q;
    assign err            = err_q;
    assign m_if.m_valid   = m_valid_q;
    assign m_if.m_cmd     = cmd_q.cmd;
    assign m_if.m_wdata   = cmd_q.wdata;
    assign m_if.m_last    = cmd_q.last;

endmodule

// File: tb/tb_pcf8591_sched.sv
// Bench for pcf8591_sched: randomized byte-master responder plus a sequence-level reference model.
module tb_pcf8591_sched;
    logic       sysclk = 1'b0;
    logic       reset  = 1'b1;
    logic       dac_req = 1'b0, adc_req = 1'b0;
    logic [7:0] dac_data = 8'h00;
    logic [1:0] adc_chan = 2'd0;
    logic       dac_ack, adc_valid, err;
    logic [7:0] adc_data;
    logic [1:0] adc_tag;

    always #5 sysclk = ~sysclk;

    pcf8591_sched_if bus();

    pcf8591_sched dut (
        .sysclk    (sysclk),
        .reset     (reset),
        .dac_req   (dac_req),
        .dac_data  (dac_data),
        .dac_ack   (dac_ack),
        .adc_req   (adc_req),
        .adc_chan  (adc_chan),
        .adc_valid (adc_valid),
        .adc_data  (adc_data),
        .adc_tag   (adc_tag),
        .err       (err),
        .m_if      (bus)
    );

    typedef logic [10:0] ent_t;   // {cmd, wdata (WRITE only), last (READ only)}

    int         n_vec = 0, n_err = 0;
    ent_t       cmd_log[$];
    ent_t       exp_q[$];
    logic [7:0] rd_log[$];
    logic [7:0] rd_fix[$];
    int         nack_sel = -1;
    int         wr_cnt = 0;
    int         lat_fix = 0;
    bit         force_stall = 1'b0;
    bit         last_adc = 1'b1;

    function automatic ent_t mk(input logic [1:0] c, input logic [7:0] w, input logic l);
        return {c, (c == 2'd1) ? w : 8'h00, (c == 2'd2) ? l : 1'b0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_vec++;
        assert (got === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
        end
    endtask

    // Byte master: random ready, random latency, NACK on a chosen write, junk nack on other commands.
    initial begin
        bit   pend, hs;
        int   cnt;
        ent_t snap, cur;
        pend = 0; hs = 0; cnt = 0; snap = '0; cur = '0;
        bus.m_ready = 0; bus.m_done = 0; bus.m_rdata = 0; bus.m_nack = 0;
        forever begin
            @(negedge sysclk);
            bus.m_done = 0;
            bus.m_nack = 0;
            if (!reset) begin
                pend = 0; hs = 0; bus.m_ready = 0;
            end else begin
                if (hs) begin
                    pend = 1;
                    cur  = snap;
                    cmd_log.push_back(cur);
                    cnt = (lat_fix > 0) ? lat_fix : $urandom_range(1, 4);
                end
                if (pend) begin
                    if (cnt <= 1) begin
                        pend = 0;
                        bus.m_done  = 1;
                        bus.m_rdata = 8'($urandom);
                        if (cur[10:9] == 2'd2) begin
                            if (rd_fix.size() > 0) bus.m_rdata = rd_fix.pop_front();
                            rd_log.push_back(bus.m_rdata);
                        end
                        if (cur[10:9] == 2'd1) begin
                            bus.m_nack = (wr_cnt == nack_sel);
                            wr_cnt++;
                        end else begin
                            bus.m_nack = 1'($urandom_range(0, 1));
                        end
                    end else begin
                        cnt--;
                    end
                end
                if (force_stall && bus.m_valid && bus.m_cmd == 2'd1 && bus.m_wdata == 8'h40)
                    bus.m_ready = 0;
                else
                    bus.m_ready = ($urandom_range(0, 3) != 0);
                hs   = bus.m_valid && bus.m_ready;
                snap = mk(bus.m_cmd, bus.m_wdata, bus.m_last);
            end
        end
    end

    // Reference: full command list for the transaction, truncated after a NACKed write plus one STOP.
    task automatic build_exp(input bit is_adc, input logic [7:0] val, input int nsel);
        ent_t full[$];
        int   w;
        bit   stop;
        w = 0; stop = 0;
        exp_q.delete();
        full.push_back(mk(2'd0, 8'h00, 1'b0));
        full.push_back(mk(2'd1, 8'h90, 1'b0));
        if (!is_adc) begin
            full.push_back(mk(2'd1, 8'h40, 1'b0));
            full.push_back(mk(2'd1, val, 1'b0));
        end else begin
            full.push_back(mk(2'd1, 8'h40 + {6'd0, val[1:0]}, 1'b0));
            full.push_back(mk(2'd3, 8'h00, 1'b0));
            full.push_back(mk(2'd0, 8'h00, 1'b0));
            full.push_back(mk(2'd1, 8'h91, 1'b0));
            full.push_back(mk(2'd2, 8'h00, 1'b0));
            full.push_back(mk(2'd2, 8'h00, 1'b1));
        end
        full.push_back(mk(2'd3, 8'h00, 1'b0));
        foreach (full[i]) begin
            if (!stop) begin
                exp_q.push_back(full[i]);
                if (full[i][10:9] == 2'd1) begin
                    if (w == nsel) begin
                        exp_q.push_back(mk(2'd3, 8'h00, 1'b0));
                        stop = 1;
                    end
                    w++;
                end
            end
        end
    endtask

    task automatic run_txn(input bit is_adc, input logic [7:0] val, input int nsel, input bit stall);
        int         stall_n;
        bit         got;
        logic [7:0] exp_d;
        stall_n = 0; got = 0; exp_d = 8'h00;
        build_exp(is_adc, val, nsel);
        @(negedge sysclk);
        cmd_log.delete(); rd_log.delete();
        nack_sel = nsel; wr_cnt = 0;
        if (is_adc) begin adc_req = 1; adc_chan = val[1:0]; end
        else        begin dac_req = 1; dac_data = val; end
        force_stall = stall;
        for (int k = 0; k < 3000 && !got; k++) begin
            @(negedge sysclk);
            if (stall && stall_n == 0 && bus.m_valid && bus.m_cmd == 2'd1 && bus.m_wdata == 8'h40) begin
                stall_n = 1;
            end else if (stall && stall_n > 0 && stall_n < 10) begin
                chk($sformatf("stall_stable%0d", stall_n),
                    {21'd0, bus.m_valid, bus.m_cmd, bus.m_wdata}, {21'd0, 1'b1, 2'd1, 8'h40});
                stall_n++;
                if (stall_n == 10) force_stall = 0;
            end
            if (dac_ack || adc_valid) got = 1;
        end
        chk("done_seen", 32'(got), 32'd1);
        chk("kind_dac", 32'(dac_ack), 32'(!is_adc));
        chk("kind_adc", 32'(adc_valid), 32'(is_adc));
        chk("err_flag", 32'(err), 32'(nsel >= 0));
        if (is_adc) begin
            if (nsel < 0) begin
                chk("nreads", rd_log.size(), 32'd2);
                if (rd_log.size() > 1) exp_d = rd_log[1];
            end
            chk("adc_data", 32'(adc_data), 32'(exp_d));
            chk("adc_tag", 32'(adc_tag), 32'(val[1:0]));
        end
        dac_req = 0; adc_req = 0;
        last_adc = is_adc;
        @(negedge sysclk);
        chk("pulse_1cyc", {29'd0, dac_ack, adc_valid, err}, 32'd0);
        chk("gap_mvalid", 32'(bus.m_valid), 32'd0);
        if (is_adc) chk("adc_data_hold", 32'(adc_data), 32'(exp_d));
        chk("ncmds", cmd_log.size(), exp_q.size());
        foreach (exp_q[i])
            if (i < cmd_log.size()) chk($sformatf("cmd%0d", i), 32'(cmd_log[i]), 32'(exp_q[i]));
        force_stall = 0;
        if (stall) chk("stall_cycles", stall_n, 32'd10);
    endtask

    // Both requests held; grants must alternate, starting with the side not granted last.
    task automatic run_both(input int n);
        bit exp_kind;
        bit got;
        exp_kind = !last_adc;
        nack_sel = -1;
        @(negedge sysclk);
        dac_req = 1; adc_req = 1;
        dac_data = 8'($urandom); adc_chan = 2'($urandom);
        for (int t = 0; t < n; t++) begin
            got = 0;
            for (int k = 0; k < 3000 && !got; k++) begin
                @(negedge sysclk);
                if (dac_ack || adc_valid) got = 1;
            end
            chk("rr_done", 32'(got), 32'd1);
            chk($sformatf("rr_order%0d", t), 32'(adc_valid), 32'(exp_kind));
            chk("rr_err", 32'(err), 32'd0);
            last_adc = exp_kind;
            exp_kind = !exp_kind;
            if (t == n - 1) begin dac_req = 0; adc_req = 0; end
        end
        @(negedge sysclk);
    endtask

    initial begin
        bit found;
        int sel, nsel;

        reset = 1'b0;
        repeat (3) @(negedge sysclk);
        chk("rst_dac_ack",   32'(dac_ack), 0);
        chk("rst_adc_valid", 32'(adc_valid), 0);
        chk("rst_adc_data",  32'(adc_data), 0);
        chk("rst_adc_tag",   32'(adc_tag), 0);
        chk("rst_err",       32'(err), 0);
        chk("rst_m_valid",   32'(bus.m_valid), 0);
        chk("rst_m_cmd",     32'(bus.m_cmd), 0);
        chk("rst_m_wdata",   32'(bus.m_wdata), 0);
        chk("rst_m_last",    32'(bus.m_last), 0);
        reset = 1'b1;
        repeat (2) @(negedge sysclk);

        lat_fix = 2;
        run_txn(1'b0, 8'hA5, -1, 1'b0);
        rd_fix.push_back(8'h11);
        rd_fix.push_back(8'h7C);
        run_txn(1'b1, 8'h02, -1, 1'b0);
        chk("adc_7c", 32'(adc_data), 32'h7C);

        lat_fix = 0;
        run_both(4);
        run_txn(1'b1, 8'($urandom_range(0, 3)), 0, 1'b0);
        run_txn(1'b0, 8'($urandom), -1, 1'b1);

        // Reset asserted while a READ is presented.
        @(negedge sysclk);
        adc_req = 1; adc_chan = 2'd1; found = 0;
        for (int k = 0; k < 2000 && !found; k++) begin
            @(negedge sysclk);
            if (bus.m_valid && bus.m_cmd == 2'd2) found = 1;
        end
        chk("read_seen", 32'(found), 32'd1);
        reset = 1'b0; adc_req = 0;
        #1;
        chk("mid_m_valid", 32'(bus.m_valid), 0);
        chk("mid_outs", {9'd0, dac_ack, adc_valid, adc_data, adc_tag, err, bus.m_cmd, bus.m_wdata, bus.m_last}, 0);
        repeat (3) @(negedge sysclk);
        reset = 1'b1;
        last_adc = 1'b1;

        // Last-grant must return to ADC on reset, so DAC wins the next tie.
        run_txn(1'b0, 8'h3C, -1, 1'b0);
        @(negedge sysclk) reset = 1'b0;
        @(negedge sysclk) reset = 1'b1;
        last_adc = 1'b1;
        run_both(2);

        for (int it = 0; it < 24; it++) begin
            sel  = $urandom_range(0, 2);
            nsel = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : -1;
            if (sel == 2) run_both(2);
            else run_txn(sel == 1, 8'($urandom), nsel, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/pcf8591_sched.md
# pcf8591_sched

Transaction scheduler for the PCF8591 ADC/DAC on the board I2C bus. It arbitrates between a DAC-write requester and an ADC-read requester and expands each granted request into the PCF8591 command sequence. It drives that sequence into a shared byte-level I2C master through a valid/ready command port, and returns read results and NACK errors to the requester.

## Interface
Parameters:
- DEV_ADDR, 7'b1001000: 7-bit PCF8591 address; write byte {DEV_ADDR,0}=0x90, read byte {DEV_ADDR,1}=0x91.
- SCAN_PERIOD, 24'd100000: autoscan interval in sysclk cycles (used only with PCF_AUTOSCAN_EN).

Ports:
- sysclk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- dac_req  in  1  DAC write request; held until dac_ack.
- dac_data  in  8  DAC value, sampled at grant.
- dac_ack  out  1  one-cycle pulse at DAC transaction end.
- adc_req  in  1  ADC read request; held until adc_valid.
- adc_chan  in  2  ADC channel, sampled at grant.
- adc_valid  out  1  one-cycle pulse with result.
- adc_data  out  8  conversion result, held until next adc_valid.
- adc_tag  out  2  channel of adc_data.
- err  out  1  one-cycle pulse at transaction end if any byte was NACKed; coincides with dac_ack/adc_valid.
- m_valid  out  1  command valid to byte master.
- m_ready  in  1  byte master accepts command.
- m_cmd  out  2  0 START, 1 WRITE, 2 READ, 3 STOP.
- m_wdata  out  8  WRITE byte.
- m_last  out  1  READ: master sends NACK after byte (1) or ACK (0).
- m_done  in  1  one-cycle pulse, command complete.
- m_rdata  in  8  READ byte, valid with m_done.
- m_nack  in  1  WRITE got NACK, valid with m_done.

## Operation
- States: IDLE, ISSUE, WAIT, ABORT, FINISH.
- IDLE: if exactly one request is active, grant it. If both are active, round-robin: grant the one not granted last. The last-grant flag resets to ADC, so DAC wins the first tie. At grant, latch dac_data or adc_chan and clear the step counter, then go to ISSUE.
- DAC sequence (5 steps): START; WRITE 0x90; WRITE 0x40; WRITE dac_data; STOP.
- ADC sequence (9 steps): START; WRITE 0x90; WRITE {6'b010000,chan}; STOP; START; WRITE 0x91; READ m_last=0 (byte discarded: previous conversion); READ m_last=1 (result); STOP.
- The control byte always has bit6=1 so the DAC output stays enabled.
- ISSUE: m_valid=1 with the step's command. On m_valid&&m_ready, go to WAIT.
- WAIT: on m_done:
  - Last READ: capture m_rdata into a result register.
  - WRITE with m_nack=1: set the error flag and go to ABORT.
  - Otherwise: if the step was the last, go to FINISH; else increment the step and go to ISSUE.
- ABORT: issue STOP and wait for m_done, then go to FINISH. The remaining steps are skipped.
- FINISH: one cycle.
  - DAC: dac_ack=1.
  - ADC: adc_valid=1, adc_tag=latched channel; adc_data=result, or 8'h00 if the error flag is set.
  - err=flag; clear the flag; return to IDLE.
- m_done outside WAIT/ABORT is ignored. m_nack on START/STOP/READ is ignored.
- Requests dropped mid-transaction do not abort; the sequence completes.

## Timing
- Reset values: dac_ack=0, adc_valid=0, adc_data=0, adc_tag=0, err=0, m_valid=0, m_cmd=0, m_wdata=0, m_last=0, state IDLE, last-grant=ADC.
- Reset mid-transaction: outputs return to reset values immediately and m_valid drops. The byte master is reset by the same signal.
- Grant is registered: the first m_valid appears 1 cycle after the request is seen in IDLE.
- m_valid, m_cmd, m_wdata and m_last are stable while m_valid=1 and m_ready=0.
- Each step costs at least 2 cycles (ISSUE, WAIT) plus the master's latency.
- The FINISH pulse follows the final m_done by 1 cycle. The next grant is evaluated 1 cycle later (in IDLE), so there are at least 2 idle cycles on m_valid between transactions.
- A request asserted in the FINISH cycle is arbitrated in the following IDLE.

## Configuration
- PCF_AUTOSCAN_EN defined:
  - Adds an internal requester driven by a 24-bit counter that wraps at SCAN_PERIOD-1.
  - At wrap it sets a scan-pending flag. The flag is arbitrated as an ADC request with lowest priority: taken only when dac_req and adc_req are both 0.
  - It uses an internal channel counter 0→1→2→3→0 that advances after each scan transaction completes.
  - Results go out on adc_valid/adc_tag the same as external reads.
  - A wrap while the flag is already set is dropped.
- PCF_AUTOSCAN_EN undefined: no counter and no flag; only external requests are served.

## Test plan
- DAC write 0xA5, master with 2-cycle latency and no NACK → commands START, W90, W40, WA5, STOP; one dac_ack; err=0.
- ADC read chan 2, master returns 0x11 then 0x7C → commands START, W90, W42, STOP, START, W91, READ(last=0), READ(last=1), STOP; adc_valid with adc_data=0x7C, adc_tag=2.
- dac_req and adc_req asserted together and held → order DAC, ADC, DAC, ADC (round-robin alternation).
- m_nack on W90 of an ADC read → one STOP issued; adc_valid with adc_data=0x00 and err=1 in the same cycle.
- m_ready held low 10 cycles during W40 → m_cmd/m_wdata stable for all 10 cycles; reset asserted mid-READ → m_valid=0 and all outputs 0 in the same cycle.
- PCF_AUTOSCAN_EN, SCAN_PERIOD=50, no requests → adc_tag sequence 0, 1, 2, 3, 0. An external dac_req asserted together with a pending scan is served first.
